// File: rtl/ysyx_22050550_muldiv_if.sv
// EXU <-> multiply/divide unit signal bundle.
// The EXU drives requests through the master modport. The muldiv unit
// answers with ready, done pulses and results through the slave modport.
interface ysyx_22050550_muldiv_if;
  logic        io_Exu_Flush;

  logic        io_Exu_MulValid;
  logic        io_Exu_Mulw;
  logic [1:0]  io_Exu_MulSigned;
  logic [63:0] io_Exu_Multiplicand;
  logic [63:0] io_Exu_Multiplier;
  logic        io_Exu_MulReady;
  logic        io_Exu_MulOutValid;
  logic [63:0] io_Exu_ResultH;
  logic [63:0] io_Exu_ResultL;

  logic        io_Exu_DivValid;
  logic        io_Exu_Divw;
  logic [1:0]  io_Exu_DivSigned;
  logic [63:0] io_Exu_Divdend;
  logic [63:0] io_Exu_Divisor;
  logic        io_Exu_DivReady;
  logic        io_Exu_DivOutValid;
  logic [63:0] io_Exu_Quotient;
  logic [63:0] io_Exu_Remainder;

  modport master (
    output io_Exu_Flush,
    output io_Exu_MulValid, io_Exu_Mulw, io_Exu_MulSigned,
    output io_Exu_Multiplicand, io_Exu_Multiplier,
    input  io_Exu_MulReady, io_Exu_MulOutValid, io_Exu_ResultH, io_Exu_ResultL,
    output io_Exu_DivValid, io_Exu_Divw, io_Exu_DivSigned,
    output io_Exu_Divdend, io_Exu_Divisor,
    input  io_Exu_DivReady, io_Exu_DivOutValid, io_Exu_Quotient, io_Exu_Remainder
  );

  modport slave (
    input  io_Exu_Flush,
    input  io_Exu_MulValid, io_Exu_Mulw, io_Exu_MulSigned,
    input  io_Exu_Multiplicand, io_Exu_Multiplier,
    output io_Exu_MulReady, io_Exu_MulOutValid, io_Exu_ResultH, io_Exu_ResultL,
    input  io_Exu_DivValid, io_Exu_Divw, io_Exu_DivSigned,
    input  io_Exu_Divdend, io_Exu_Divisor,
    output io_Exu_DivReady, io_Exu_DivOutValid, io_Exu_Quotient, io_Exu_Remainder
  );
endinterface

// File: rtl/ysyx_22050550_muldiv.sv
// Iterative 64-bit multiply / divide unit for RV64M.
// Two independent engines (shift-add multiplier, restoring divider) each
// retire one bit per cycle on operand magnitudes, then apply a sign fix-up
// in one extra cycle before presenting a one-cycle done pulse.
module ysyx_22050550_muldiv (
  input  logic                         clock,
  input  logic                         reset,
  ysyx_22050550_muldiv_if.slave        exu
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Extends an operand (full 64-bit or low 32-bit word) and splits it into
  // {is_negative, magnitude}. The most negative value maps onto a magnitude
  // of 2^63 (or 2^31), which still fits in 64 unsigned bits.
  function automatic logic [64:0] cond_operand(input logic [63:0] x,
                                               input logic        w,
                                               input logic        s);
    logic [63:0] raw;
    logic        neg;
    raw = w ? {{32{s & x[31]}}, x[31:0]} : x;
    neg = w ? (s & x[31]) : (s & x[63]);
    return {neg, (neg ? (~raw + 64'd1) : raw)};
  endfunction

  // --------------------------------------------------------------------
  // Multiplier
  // --------------------------------------------------------------------
  state_t       mul_state_reg;
  logic         mul_ready_reg;
  logic         mul_out_valid_reg;
  logic [6:0]   mul_cnt_reg;
  logic         mul_w_reg;
  logic         mul_neg_reg;
  logic [127:0] mul_acc_reg;
  logic [127:0] mul_mcand_reg;
  logic [63:0]  mul_mplier_reg;
  logic [63:0]  mul_res_h_reg;
  logic [63:0]  mul_res_l_reg;

  logic         mul_accept;
  logic [64:0]  mul_a_cond;
  logic [64:0]  mul_b_cond;
  logic [127:0] mul_prod;

  // Flush has priority over a same-cycle request.
  assign mul_accept = exu.io_Exu_MulValid & mul_ready_reg & ~exu.io_Exu_Flush;
  assign mul_a_cond = cond_operand(exu.io_Exu_Multiplicand, exu.io_Exu_Mulw,
                                   exu.io_Exu_MulSigned[1]);
  assign mul_b_cond = cond_operand(exu.io_Exu_Multiplier, exu.io_Exu_Mulw,
                                   exu.io_Exu_MulSigned[0]);
  // Magnitude product with the sign restored; modulo 2^128 this is the
  // exact two's-complement product for every signedness combination.
  assign mul_prod   = mul_neg_reg ? (~mul_acc_reg + 128'd1) : mul_acc_reg;

  // Multiplier FSM: capture on accept, N shift-add steps, sign fix-up, pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      mul_state_reg     <= ST_IDLE;
      mul_ready_reg     <= 1'b1;
      mul_out_valid_reg <= 1'b0;
      mul_cnt_reg       <= '0;
      mul_w_reg         <= 1'b0;
      mul_neg_reg       <= 1'b0;
      mul_acc_reg       <= '0;
      mul_mcand_reg     <= '0;
      mul_mplier_reg    <= '0;
      mul_res_h_reg     <= '0;
      mul_res_l_reg     <= '0;
    end else if (exu.io_Exu_Flush) begin
      mul_state_reg     <= ST_IDLE;
      mul_ready_reg     <= 1'b1;
      mul_out_valid_reg <= 1'b0;
    end else begin
      case (mul_state_reg)
        ST_BUSY: begin
          if (mul_cnt_reg != 7'd0) begin
            if (mul_mplier_reg[0]) begin
              mul_acc_reg <= mul_acc_reg + mul_mcand_reg;
            end
            mul_mcand_reg  <= {mul_mcand_reg[126:0], 1'b0};
            mul_mplier_reg <= {1'b0, mul_mplier_reg[63:1]};
            mul_cnt_reg    <= mul_cnt_reg - 7'd1;
          end else begin
            if (mul_w_reg) begin
              mul_res_h_reg <= '0;
              mul_res_l_reg <= {{32{mul_prod[31]}}, mul_prod[31:0]};
            end else begin
              mul_res_h_reg <= mul_prod[127:64];
              mul_res_l_reg <= mul_prod[63:0];
            end
            mul_out_valid_reg <= 1'b1;
            mul_ready_reg     <= 1'b1;
            mul_state_reg     <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE allows a back-to-back request.
          mul_out_valid_reg <= 1'b0;
          if (mul_accept) begin
            mul_state_reg  <= ST_BUSY;
            mul_ready_reg  <= 1'b0;
            mul_cnt_reg    <= exu.io_Exu_Mulw ? 7'd32 : 7'd64;
            mul_w_reg      <= exu.io_Exu_Mulw;
            mul_neg_reg    <= mul_a_cond[64] ^ mul_b_cond[64];
            mul_acc_reg    <= '0;
            mul_mcand_reg  <= {64'd0, mul_a_cond[63:0]};
            mul_mplier_reg <= mul_b_cond[63:0];
          end else begin
            mul_state_reg  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign exu.io_Exu_MulReady    = mul_ready_reg;
  assign exu.io_Exu_MulOutValid = mul_out_valid_reg;
  assign exu.io_Exu_ResultH     = mul_res_h_reg;
  assign exu.io_Exu_ResultL     = mul_res_l_reg;

  // --------------------------------------------------------------------
  // Divider
  // --------------------------------------------------------------------
  state_t       div_state_reg;
  logic         div_ready_reg;
  logic         div_out_valid_reg;
  logic [6:0]   div_cnt_reg;
  logic         div_w_reg;
  logic         div_q_neg_reg;
  logic         div_r_neg_reg;
  logic         div_zero_reg;
  logic [63:0]  div_dvd_reg;    // original dividend, returned on divide-by-zero
  logic [63:0]  div_quo_reg;    // dividend bits shift out the top, quotient bits in
  logic [63:0]  div_rem_reg;
  logic [63:0]  div_dsr_reg;
  logic [63:0]  div_q_out_reg;
  logic [63:0]  div_r_out_reg;

  logic         div_accept;
  logic [64:0]  div_a_cond;
  logic [64:0]  div_b_cond;
  logic [64:0]  div_shift;
  logic [65:0]  div_trial;
  logic         div_ge;
  logic [63:0]  div_q_fix;
  logic [63:0]  div_r_fix;
  logic [63:0]  div_q_sel;
  logic [63:0]  div_r_sel;

  assign div_accept = exu.io_Exu_DivValid & div_ready_reg & ~exu.io_Exu_Flush;
  // Only bit 0 of the signedness field selects signed division.
  assign div_a_cond = cond_operand(exu.io_Exu_Divdend, exu.io_Exu_Divw,
                                   exu.io_Exu_DivSigned[0]);
  assign div_b_cond = cond_operand(exu.io_Exu_Divisor, exu.io_Exu_Divw,
                                   exu.io_Exu_DivSigned[0]);

  // One restoring step: bring down the next dividend bit and try to
  // subtract. 66 bits so the borrow is unambiguous for a 65-bit partial.
  assign div_shift = {div_rem_reg, div_quo_reg[63]};
  assign div_trial = {1'b0, div_shift} - {2'b00, div_dsr_reg};
  assign div_ge    = ~div_trial[65];

  // Sign fix-up. Signed overflow (most-negative / -1) needs no special
  // case: magnitude 2^63 (2^31) negated wraps back onto the dividend.
  assign div_q_fix = div_q_neg_reg ? (~div_quo_reg + 64'd1) : div_quo_reg;
  assign div_r_fix = div_r_neg_reg ? (~div_rem_reg + 64'd1) : div_rem_reg;
  assign div_q_sel = div_zero_reg ? {64{1'b1}} : div_q_fix;
  assign div_r_sel = div_zero_reg ? div_dvd_reg : div_r_fix;

  // Divider FSM: capture on accept, N restoring steps, sign fix-up, pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_state_reg     <= ST_IDLE;
      div_ready_reg     <= 1'b1;
      div_out_valid_reg <= 1'b0;
      div_cnt_reg       <= '0;
      div_w_reg         <= 1'b0;
      div_q_neg_reg     <= 1'b0;
      div_r_neg_reg     <= 1'b0;
      div_zero_reg      <= 1'b0;
      div_dvd_reg       <= '0;
      div_quo_reg       <= '0;
      div_rem_reg       <= '0;
      div_dsr_reg       <= '0;
      div_q_out_reg     <= '0;
      div_r_out_reg     <= '0;
    end else if (exu.io_Exu_Flush) begin
      div_state_reg     <= ST_IDLE;
      div_ready_reg     <= 1'b1;
      div_out_valid_reg <= 1'b0;
    end else begin
      case (div_state_reg)
        ST_BUSY: begin
          if (div_cnt_reg != 7'd0) begin
            div_rem_reg <= div_ge ? div_trial[63:0] : div_shift[63:0];
            div_quo_reg <= {div_quo_reg[62:0], div_ge};
            div_cnt_reg <= div_cnt_reg - 7'd1;
          end else begin
            if (div_w_reg) begin
              div_q_out_reg <= {{32{div_q_sel[31]}}, div_q_sel[31:0]};
              div_r_out_reg <= {{32{div_r_sel[31]}}, div_r_sel[31:0]};
            end else begin
              div_q_out_reg <= div_q_sel;
              div_r_out_reg <= div_r_sel;
            end
            div_out_valid_reg <= 1'b1;
            div_ready_reg     <= 1'b1;
            div_state_reg     <= ST_DONE;
          end
        end
        default: begin
          div_out_valid_reg <= 1'b0;
          if (div_accept) begin
            div_state_reg <= ST_BUSY;
            div_ready_reg <= 1'b0;
            div_cnt_reg   <= exu.io_Exu_Divw ? 7'd32 : 7'd64;
            div_w_reg     <= exu.io_Exu_Divw;
            div_q_neg_reg <= div_a_cond[64] ^ div_b_cond[64];
            div_r_neg_reg <= div_a_cond[64];
            div_zero_reg  <= (div_b_cond[63:0] == 64'd0);
            div_dvd_reg   <= exu.io_Exu_Divdend;
            div_rem_reg   <= '0;
            div_dsr_reg   <= div_b_cond[63:0];
            // Word ops park the 32-bit magnitude at the top so the first
            // step already sees its MSB.
            div_quo_reg   <= exu.io_Exu_Divw ? {div_a_cond[31:0], 32'd0}
                                             : div_a_cond[63:0];
          end else begin
            div_state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign exu.io_Exu_DivReady    = div_ready_reg;
  assign exu.io_Exu_DivOutValid = div_out_valid_reg;
  assign exu.io_Exu_Quotient    = div_q_out_reg;
  assign exu.io_Exu_Remainder   = div_r_out_reg;

endmodule

// File: tb/tb_ysyx_22050550_muldiv.sv
// Randomised scoreboard bench for the multiply/divide unit.
// Drivers push expected results (from a plain-arithmetic model) into queues;
// a monitor pops and compares on every done pulse and checks ready / hold
// behaviour on all other cycles.
module tb_ysyx_22050550_muldiv;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_22050550_muldiv_if io();

  ysyx_22050550_muldiv dut (
    .clock (clock),
    .reset (reset),
    .exu   (io)
  );

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    int          due;
    string       tag;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t mul_q[$];
  exp_t div_q[$];
  logic [63:0] mul_hold_h, mul_hold_l, div_hold_q, div_hold_r;
  bit   mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic w, input logic [1:0] s);
    logic [127:0] ea, eb, p;
    if (w) begin
      ea = s[1] ? {{96{a[31]}}, a[31:0]} : {96'd0, a[31:0]};
      eb = s[0] ? {{96{b[31]}}, b[31:0]} : {96'd0, b[31:0]};
      p  = ea * eb;
      return {64'd0, sx32(p[31:0])};
    end
    ea = s[1] ? {{64{a[63]}}, a} : {64'd0, a};
    eb = s[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  // Returns {quotient, remainder}.
  function automatic logic [127:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                           input logic w, input logic s);
    logic [63:0] q, r;
    logic [31:0] a32, b32;
    int          sa, sb;
    longint      la, lb;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin
        q = '1; r = sx32(a32);
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q = sx32(a32); r = '0;
      end else if (s) begin
        sa = a32; sb = b32;
        q = sx32(32'(sa / sb)); r = sx32(32'(sa % sb));
      end else begin
        q = sx32(a32 / b32); r = sx32(a32 % b32);
      end
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0;
      end else if (s) begin
        la = a; lb = b;
        q = 64'(la / lb); r = 64'(la % lb);
      end else begin
        q = a / b; r = a % b;
      end
    end
    return {q, r};
  endfunction

  // ---------------- drivers (caller sits at a negedge) ----------------
  task automatic mul_issue(input logic [63:0] a, input logic [63:0] b, input logic w,
                           input logic [1:0] s, input bit hold);
    int guard = 0;
    exp_t e;
    logic [127:0] p;
    io.io_Exu_MulValid     = 1'b1;
    io.io_Exu_Multiplicand = a;
    io.io_Exu_Multiplier   = b;
    io.io_Exu_Mulw         = w;
    io.io_Exu_MulSigned    = s;
    while (io.io_Exu_MulReady !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL mul_ready_timeout actual=busy required=ready");
      io.io_Exu_MulValid = 1'b0;
      return;
    end
    p     = ref_mul(a, b, w, s);
    e.x   = p[127:64];
    e.y   = p[63:0];
    e.due = cyc + (w ? 32 : 64) + 2;
    e.tag = $sformatf("mul a=%h b=%h w=%0b s=%b", a, b, w, s);
    @(posedge clock);
    mul_q.push_back(e);
    @(negedge clock);
    if (!hold) io.io_Exu_MulValid = 1'b0;
  endtask

  task automatic div_issue(input logic [63:0] a, input logic [63:0] b, input logic w,
                           input logic [1:0] s);
    int guard = 0;
    exp_t e;
    logic [127:0] qr;
    io.io_Exu_DivValid  = 1'b1;
    io.io_Exu_Divdend   = a;
    io.io_Exu_Divisor   = b;
    io.io_Exu_Divw      = w;
    io.io_Exu_DivSigned = s;
    while (io.io_Exu_DivReady !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL div_ready_timeout actual=busy required=ready");
      io.io_Exu_DivValid = 1'b0;
      return;
    end
    qr    = ref_div(a, b, w, s[0]);
    e.x   = qr[127:64];
    e.y   = qr[63:0];
    e.due = cyc + (w ? 32 : 64) + 2;
    e.tag = $sformatf("div a=%h b=%h w=%0b s=%b", a, b, w, s);
    @(posedge clock);
    div_q.push_back(e);
    @(negedge clock);
    io.io_Exu_DivValid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((mul_q.size() != 0 || div_q.size() != 0) && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", mul_q.size(), div_q.size());
      mul_q.delete();
      div_q.delete();
    end
    @(negedge clock);
  endtask

  // Flush (use_reset=0) or reset (use_reset=1) ten cycles into a divide.
  task automatic abort_div(input bit use_reset);
    div_issue(64'd1000, 64'd3, 1'b0, 2'b00);
    repeat (9) @(negedge clock);
    if (use_reset) reset = 1'b1;
    else           io.io_Exu_Flush = 1'b1;
    @(posedge clock);
    mul_q.delete();
    div_q.delete();
    if (use_reset) begin
      mul_hold_h = '0; mul_hold_l = '0; div_hold_q = '0; div_hold_r = '0;
    end
    @(negedge clock);
    reset = 1'b0;
    io.io_Exu_Flush = 1'b0;
    check64(use_reset ? "reset_abort_divready" : "flush_abort_divready",
            64'(io.io_Exu_DivReady), 64'd1);
    div_issue(64'd100, 64'd7, 1'b0, 2'b00);
    drain();
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = '1;
      3: v = 64'h8000_0000_0000_0000;
      4: v = {$urandom, 32'h8000_0000};
      5: v = 64'($urandom_range(0, 20));
      6: v = {32'd0, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clock);
      if (io.io_Exu_MulOutValid === 1'b1) begin
        if (mul_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mul_unexpected_outvalid actual=1 required=0");
        end else begin
          e = mul_q.pop_front();
          check64({e.tag, " hi"}, io.io_Exu_ResultH, e.x);
          check64({e.tag, " lo"}, io.io_Exu_ResultL, e.y);
          check_int({e.tag, " latency_cycle"}, cyc, e.due);
          check64({e.tag, " ready_in_done"}, 64'(io.io_Exu_MulReady), 64'd1);
          mul_hold_h = e.x;
          mul_hold_l = e.y;
        end
      end else begin
        check64("mul_ready", 64'(io.io_Exu_MulReady), (mul_q.size() == 0) ? 64'd1 : 64'd0);
        check64("mul_hold_h", io.io_Exu_ResultH, mul_hold_h);
        check64("mul_hold_l", io.io_Exu_ResultL, mul_hold_l);
      end
      if (io.io_Exu_DivOutValid === 1'b1) begin
        if (div_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL div_unexpected_outvalid actual=1 required=0");
        end else begin
          e = div_q.pop_front();
          check64({e.tag, " quo"}, io.io_Exu_Quotient, e.x);
          check64({e.tag, " rem"}, io.io_Exu_Remainder, e.y);
          check_int({e.tag, " latency_cycle"}, cyc, e.due);
          check64({e.tag, " ready_in_done"}, 64'(io.io_Exu_DivReady), 64'd1);
          div_hold_q = e.x;
          div_hold_r = e.y;
        end
      end else begin
        check64("div_ready", 64'(io.io_Exu_DivReady), (div_q.size() == 0) ? 64'd1 : 64'd0);
        check64("div_hold_q", io.io_Exu_Quotient, div_hold_q);
        check64("div_hold_r", io.io_Exu_Remainder, div_hold_r);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    io.io_Exu_Flush        = 1'b0;
    io.io_Exu_MulValid     = 1'b0;
    io.io_Exu_Mulw         = 1'b0;
    io.io_Exu_MulSigned    = 2'b00;
    io.io_Exu_Multiplicand = '0;
    io.io_Exu_Multiplier   = '0;
    io.io_Exu_DivValid     = 1'b0;
    io.io_Exu_Divw         = 1'b0;
    io.io_Exu_DivSigned    = 2'b00;
    io.io_Exu_Divdend      = '0;
    io.io_Exu_Divisor      = '0;
    mul_hold_h = '0; mul_hold_l = '0; div_hold_q = '0; div_hold_r = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check64("reset_mul_outvalid", 64'(io.io_Exu_MulOutValid), 64'd0);
    check64("reset_div_outvalid", 64'(io.io_Exu_DivOutValid), 64'd0);
    mon_en = 1'b1;

    // Directed multiplies and divides.
    mul_issue(64'd3, 64'd5, 1'b0, 2'b00, 1'b0);
    drain();
    mul_issue('1, 64'd2, 1'b0, 2'b11, 1'b0);
    drain();
    mul_issue('1, 64'd2, 1'b0, 2'b00, 1'b0);
    drain();
    mul_issue(64'h4000_0000, 64'd2, 1'b1, 2'b11, 1'b0);
    drain();
    div_issue(64'd100, 64'd7, 1'b0, 2'b00);
    drain();
    div_issue(-64'sd7, 64'd2, 1'b0, 2'b11);
    drain();
    div_issue(64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 2'b00);
    drain();
    div_issue(64'h8000_0000_0000_0000, '1, 1'b0, 2'b11);
    drain();
    div_issue(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 2'b11);
    drain();

    // Abort by flush, then by reset.
    abort_div(1'b0);
    abort_div(1'b1);

    // Back-to-back: valid held high across completion.
    mul_issue(64'd7, 64'd9, 1'b0, 2'b00, 1'b1);
    mul_issue(-64'sd3, 64'd11, 1'b0, 2'b11, 1'b1);
    mul_issue(64'hFFFF_0000_1234, 64'h10, 1'b1, 2'b10, 1'b0);
    drain();

    // Randomised concurrent traffic on both engines.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          mul_issue(pick(), pick(), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        io.io_Exu_MulValid = 1'b0;
      end
      begin
        for (int j = 0; j < 30; j++) begin
          div_issue(pick(), pick(), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00);
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_muldiv.md
Name: ysyx_22050550_muldiv

Overview:
- Iterative 64-bit integer multiply/divide unit used by the EXU for RV64M MUL/MULW/DIV/DIVU-class ops.
- Two independent engines (multiplier, divider) share one clock/reset/flush; each has its own valid/ready request and one-cycle OutValid result pulse.
- EXU stalls while an engine is busy and latches the result on OutValid.

Parameters:
- None; datapath fixed at XLEN=64.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- io_Exu_Flush  in  1  abort any in-flight op in both engines
- io_Exu_MulValid  in  1  multiply request
- io_Exu_Mulw  in  1  32-bit (MULW) op
- io_Exu_MulSigned  in  2  [1]=multiplicand signed, [0]=multiplier signed
- io_Exu_Multiplicand  in  64  operand A
- io_Exu_Multiplier  in  64  operand B
- io_Exu_MulReady  out  1  multiplier idle, can accept
- io_Exu_MulOutValid  out  1  one-cycle multiply-done pulse
- io_Exu_ResultH  out  64  product[127:64]
- io_Exu_ResultL  out  64  product[63:0]
- io_Exu_DivValid  in  1  divide request
- io_Exu_Divw  in  1  32-bit (DIVW/REMW) op
- io_Exu_DivSigned  in  2  2'b11 signed, 2'b00 unsigned; bit[0] decides
- io_Exu_Divdend  in  64  dividend
- io_Exu_Divisor  in  64  divisor
- io_Exu_DivReady  out  1  divider idle, can accept
- io_Exu_DivOutValid  out  1  one-cycle divide-done pulse
- io_Exu_Quotient  out  64  quotient
- io_Exu_Remainder  out  64  remainder

Behaviour:
- Reset: both engines IDLE; Ready=1; OutValid=0; all result outputs 0. Reset mid-operation discards the op with no OutValid.
- Each engine FSM: IDLE -> BUSY -> DONE -> IDLE.
- Accept: Valid && Ready at rising edge E0. Operands, Mulw/Divw and Signed are captured at E0; inputs may change afterwards.
- BUSY: Ready=0; Valid is ignored.
- Iteration: one bit per cycle. N=64 for 64-bit ops, N=32 for W ops. Last iteration on edge E0+N.
- DONE: OutValid=1 for exactly the cycle after edge E0+N+1; Ready=1 in that same cycle, so a back-to-back accept is allowed.
- Results: registered and held stable from OutValid until the next accepted op completes.
- Flush: forces both engines to IDLE at the next edge; no OutValid. Flush and Valid in the same cycle: flush wins, no accept.
- Multiply (64-bit): operands sign- or zero-extended per MulSigned bits; ResultH:ResultL = full 128-bit product.
- MULW: operands are low 32 bits extended per MulSigned; ResultL = sign-extend(product[31:0]); ResultH = 0.
- Divide (64-bit): quotient truncates toward zero; remainder takes the dividend's sign; magnitude restoring division with sign fix-up.
- DIVW/REMW: uses low 32 bits, extended per signedness; Quotient and Remainder each sign-extended from bit 31.
- Divisor zero: Quotient = all ones; Remainder = dividend (W: sign-extended low 32).
- Signed overflow (most-negative / -1): Quotient = dividend; Remainder = 0.
- Special cases keep the same fixed latency.
- Both engines may run concurrently; each OutValid is independent.

Test Plan:
- Unsigned mul 3 x 5, MulSigned=00 -> ResultL=15, ResultH=0; OutValid one cycle, 65 cycles after accept; Ready low in between.
- Signed and unsigned mul:
  - 0xFFFF_FFFF_FFFF_FFFF x 2, MulSigned=11 -> ResultL=0xFFFF_FFFF_FFFF_FFFE, ResultH=all ones.
  - Same operands, MulSigned=00 -> ResultH=1.
- MULW 0x4000_0000 x 2 -> ResultL=0xFFFF_FFFF_8000_0000, ResultH=0, 33-cycle latency.
- Divide cases:
  - Unsigned 100 / 7 -> Q=14, R=2.
  - Signed -7 / 2 -> Q=-3, R=-1.
  - x / 0 -> Q=0xFFFF_FFFF_FFFF_FFFF, R=x.
  - 0x8000_0000_0000_0000 / -1 signed -> Q=0x8000_0000_0000_0000, R=0.
- Abort: Flush asserted 10 cycles into a divide -> no DivOutValid, DivReady=1 next cycle; a new divide then gives the correct result. Repeat the scenario with reset in place of Flush.
- Back-to-back: hold MulValid high across completion -> second op accepted in the OutValid cycle; results held stable between pulses.
